ahb_write_sequencer: RTL and testbench
======================================

// Module: ahb_write_sequencer
// PURPOSE
// - Master-side controller for the AHB register-write slave: accepts 3-byte write
//   jobs (payload_0, payload_1, data_size) from N_REQ requesters.
// - Round-robin arbitrates between requesters, then sequences three single-beat
//   writes (write_select 0,1,2) into the slave.
// - Checks the registered hresp after each beat, retries failed beats, and
//   reports per-job completion and error status to the granted requester.
// PARAMETERS
// - N_REQ      2  number of requesters (>=2)
// - MAX_RETRY  2  extra attempts per beat after hresp error; 0 = no retry
// - RCNT_W     2  retry counter width, must hold MAX_RETRY
// PORTS
// - hclk           in   1        clock; all logic on posedge
// - hreset         in   1        reset, synchronous, active-high
// - req_valid      in   N_REQ    requester i has a job pending
// - req_payload_0  in   N_REQ*8  byte for write_select 0, slice i = requester i
// - req_payload_1  in   N_REQ*8  byte for write_select 1
// - req_data_size  in   N_REQ*5  value for write_select 2
// - req_ready      out  N_REQ    one-hot accept strobe; job latched this cycle
// - hsel_x         out  1        slave select
// - hwrite         out  1        write strobe
// - hready         out  1        transfer-ready qualifier
// - write_select   out  2        target register: 0=payload_0, 1=payload_1, 2=data_size
// - hwdata         out  8        write data; data_size is zero-extended to 8 bits
// - hresp          in   1        slave response, registered; 1 = error for the previous beat
// - done_valid     out  1        1-cycle pulse: job finished
// - done_id        out  clog2(N_REQ) requester that owned the finished job
// - done_err       out  1        job aborted: retries exhausted
// - done_beat      out  2        failing write_select when done_err=1, else 0
// - busy           out  1        state != IDLE
// BEHAVIOUR
// - Reset (sync, hreset=1 at posedge):
//   - State -> IDLE; the RR pointer selects requester 0 first.
//   - All outputs 0: hsel_x, hwrite, hready, write_select, hwdata, req_ready,
//     done_*, busy.
//   - A job in flight is dropped silently: no done_valid pulse.
// - State machine: IDLE -> ISSUE -> CHECK -> (ISSUE | DONE) -> IDLE.
// - IDLE:
//   - If any req_valid is set, req_ready[g]=1 in the same cycle for the RR winner g.
//   - Job fields and g are latched; beat=0, retry_cnt=0; next state ISSUE.
//   - req_ready is combinational from state, req_valid and the pointer. All other
//     outputs come from flops.
// - ISSUE (exactly 1 cycle):
//   - hsel_x=hwrite=hready=1.
//   - write_select=beat; hwdata=latched byte for that beat.
// - CHECK (1 cycle):
//   - Bus idle: hsel_x=hwrite=hready=0, write_select and hwdata hold.
//   - hresp is sampled here.
//   - hresp=0: beat<2 -> beat++, retry_cnt=0, go to ISSUE; beat==2 -> DONE, done_err=0.
//   - hresp=1 and retry_cnt<MAX_RETRY: retry_cnt++, go to ISSUE on the same beat.
//   - hresp=1 and retry_cnt==MAX_RETRY: go to DONE with done_err=1, done_beat=beat.
//     Remaining beats are not issued.
// - DONE (1 cycle):
//   - done_valid=1, done_id=g; done_err and done_beat as set in CHECK.
//   - RR pointer <= g+1 (mod N_REQ).
//   - Next state IDLE; no accept in DONE.
// - Latency:
//   - Error-free job: accept at cycle T, ISSUE at T+1/T+3/T+5, done_valid at T+7.
//   - Next accept no earlier than T+8.
//   - Each retry adds 2 cycles.
// - Arbitration:
//   - Search starts at the pointer and wraps past N_REQ-1 to 0.
//   - The pointer advances only in DONE.
//   - A requester that deasserts valid is skipped.
// - Requester rule: req_valid and data are held until req_ready; they are not
//   sampled after accept.
// - Boundary cases:
//   - hresp outside CHECK is ignored.
//   - With MAX_RETRY=0, the first error aborts the job.
//   - Only one job is ever outstanding.
// STRUCTURE
// - Shared package ahb_pkg:
//   - WSEL_PAYLOAD_0=2'd0, WSEL_PAYLOAD_1=2'd1, WSEL_DATA_SIZE=2'd2.
//   - typedef enum seq_state_t {IDLE, ISSUE, CHECK, DONE}.
// - Sub-module ahb_rr_arbiter #(N_REQ):
//   - Inputs: req, ptr, enable.
//   - Outputs: one-hot gnt and gnt_id; purely combinational.
// - The sequencer FSM, job registers and retry counter live in this module.
// TESTING
// 1. Reset, req_valid=01, payload 8'hA5/8'h3C, size 5'd17, hresp=0
//    -> writes (0,A5),(1,3C),(2,11) on cycles T+1/3/5; done at T+7, err=0, id=0.
// 2. req_valid=11 held for 3 jobs -> grant order 0,1,0; done_id follows.
// 3. hresp=1 once in the beat-1 CHECK, MAX_RETRY=2
//    -> beat 1 reissued once; done at T+9, err=0.
// 4. hresp=1 in every beat-0 CHECK
//    -> 3 attempts, then done_err=1, done_beat=0; beats 1 and 2 never issued.
// 5. hreset=1 during beat-1 ISSUE
//    -> next cycle all outputs 0, state IDLE, no done_valid; requester 0 wins next.
// 6. hresp=1 pulsed in IDLE and ISSUE cycles -> ignored; job completes with err=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared definitions for the AHB register-write sequencer: register select codes,
// sequencer state encoding and the beat-to-data mux.
package ahb_pkg;

  localparam logic [1:0] WSEL_PAYLOAD_0 = 2'd0;
  localparam logic [1:0] WSEL_PAYLOAD_1 = 2'd1;
  localparam logic [1:0] WSEL_DATA_SIZE = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} seq_state_t;

  function automatic logic [7:0] beat_data(input logic [1:0] wsel,
                                           input logic [7:0] p0,
                                           input logic [7:0] p1,
                                           input logic [4:0] sz);
    case (wsel)
      WSEL_PAYLOAD_0: beat_data = p0;
      WSEL_PAYLOAD_1: beat_data = p1;
      default:        beat_data = {3'b000, sz};
    endcase
  endfunction

endpackage

// File: rtl/ahb_write_sequencer_if.sv
// Requester, AHB write and completion signals of the write sequencer.
// master = sequencer side, slave = requesters plus register slave.
interface ahb_write_sequencer_if #(
  parameter int N_REQ = 2
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*8-1:0] req_payload_0;
  logic [N_REQ*8-1:0] req_payload_1;
  logic [N_REQ*5-1:0] req_data_size;
  logic [N_REQ-1:0]   req_ready;
  logic               hsel_x;
  logic               hwrite;
  logic               hready;
  logic [1:0]         write_select;
  logic [7:0]         hwdata;
  logic               hresp;
  logic               done_valid;
  logic [ID_W-1:0]    done_id;
  logic               done_err;
  logic [1:0]         done_beat;
  logic               busy;

  modport master (
    input  req_valid, req_payload_0, req_payload_1, req_data_size, hresp,
    output req_ready, hsel_x, hwrite, hready, write_select, hwdata,
           done_valid, done_id, done_err, done_beat, busy
  );

  modport slave (
    output req_valid, req_payload_0, req_payload_1, req_data_size, hresp,
    input  req_ready, hsel_x, hwrite, hready, write_select, hwdata,
           done_valid, done_id, done_err, done_beat, busy
  );

endinterface

// File: rtl/ahb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping,
// wins; nothing is granted while enable_i is low.
module ahb_rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             enable_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr_i) + k) % N_REQ);
      if (enable_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_write_sequencer.sv
// Arbitrates 3-byte write jobs from N_REQ requesters and issues them as three
// single-beat AHB writes with per-beat retry on registered hresp errors.
//
// state | meaning
// IDLE  | waiting for a job; req_ready strobes the RR winner
// ISSUE | one write beat on the bus
// CHECK | bus idle, hresp for the previous beat sampled
// DONE  | done_valid pulse, RR pointer advances past the owner
module ahb_write_sequencer
  import ahb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_RETRY = 2,
  parameter int RCNT_W    = 2
) (
  input logic                   hclk,
  input logic                   hreset,
  ahb_write_sequencer_if.master bus
);

  localparam int ID_W = $clog2(N_REQ);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_CHECK = CHECK;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [RCNT_W-1:0] RETRY_LIMIT = RCNT_W'(MAX_RETRY);
  localparam logic [ID_W-1:0]   LAST_ID     = ID_W'(N_REQ - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [RCNT_W-1:0] retry_q, retry_d;
  logic              err_q, err_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [7:0]        p0_q, p0_d;
  logic [7:0]        p1_q, p1_d;
  logic [4:0]        sz_q, sz_d;

  logic              bus_act_q;
  logic [1:0]        wsel_q;
  logic [7:0]        hwdata_q;
  logic              done_valid_q;
  logic [ID_W-1:0]   done_id_q;
  logic              done_err_q;
  logic [1:0]        done_beat_q;
  logic              busy_q;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [7:0]        sel_p0, sel_p1;
  logic [4:0]        sel_sz;

  ahb_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i    (bus.req_valid),
    .ptr_i    (ptr_q),
    .enable_i (state_q == ST_IDLE),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  always_comb begin
    sel_p0 = '0;
    sel_p1 = '0;
    sel_sz = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_p0 = bus.req_payload_0[i*8 +: 8];
        sel_p1 = bus.req_payload_1[i*8 +: 8];
        sel_sz = bus.req_data_size[i*5 +: 5];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    retry_d = retry_q;
    err_d   = err_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    sz_d    = sz_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          gid_d   = gnt_id;
          p0_d    = sel_p0;
          p1_d    = sel_p1;
          sz_d    = sel_sz;
          beat_d  = WSEL_PAYLOAD_0;
          retry_d = '0;
          err_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (!bus.hresp) begin
          if (beat_q == WSEL_DATA_SIZE) begin
            state_d = ST_DONE;
          end else begin
            beat_d  = beat_q + 2'd1;
            retry_d = '0;
            state_d = ST_ISSUE;
          end
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and completion outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      retry_q      <= '0;
      err_q        <= 1'b0;
      gid_q        <= '0;
      ptr_q        <= '0;
      p0_q         <= '0;
      p1_q         <= '0;
      sz_q         <= '0;
      bus_act_q    <= 1'b0;
      wsel_q       <= '0;
      hwdata_q     <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_err_q   <= 1'b0;
      done_beat_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      retry_q      <= retry_d;
      err_q        <= err_d;
      gid_q        <= gid_d;
      ptr_q        <= ptr_d;
      p0_q         <= p0_d;
      p1_q         <= p1_d;
      sz_q         <= sz_d;
      bus_act_q    <= (state_d == ST_ISSUE);
      if (state_d == ST_ISSUE) begin
        wsel_q   <= beat_d;
        hwdata_q <= beat_data(beat_d, p0_d, p1_d, sz_d);
      end
      done_valid_q <= (state_d == ST_DONE);
      done_id_q    <= (state_d == ST_DONE) ? gid_q : '0;
      done_err_q   <= (state_d == ST_DONE) && err_d;
      done_beat_q  <= ((state_d == ST_DONE) && err_d) ? beat_q : '0;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign bus.req_ready    = gnt;
  assign bus.hsel_x       = bus_act_q;
  assign bus.hwrite       = bus_act_q;
  assign bus.hready       = bus_act_q;
  assign bus.write_select = wsel_q;
  assign bus.hwdata       = hwdata_q;
  assign bus.done_valid   = done_valid_q;
  assign bus.done_id      = done_id_q;
  assign bus.done_err     = done_err_q;
  assign bus.done_beat    = done_beat_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_ahb_write_sequencer.sv
// Scoreboard bench for ahb_write_sequencer: expected beats and completions are
// queued at job accept and popped as the DUT produces them.
module tb_ahb_write_sequencer;
  import ahb_pkg::*;

  localparam int N_REQ     = 2;
  localparam int MAX_RETRY = 2;
  localparam int ID_W      = 1;

  typedef struct packed {
    logic [1:0]  wsel;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            err;
    logic [1:0]      beat;
    logic [31:0]     cyc;
  } done_t;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  int   cyc = 0;

  ahb_write_sequencer_if #(.N_REQ(N_REQ)) bus ();

  ahb_write_sequencer #(.N_REQ(N_REQ), .MAX_RETRY(MAX_RETRY), .RCNT_W(2)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  wr_t   write_q[$];
  done_t done_q[$];
  int    fails[3];
  int    att[3];
  int    jobs_left[N_REQ];
  int    exp_ptr;
  int    pend_g;
  int    win;
  logic  noise;
  logic  fail_next;
  logic  last_issue;
  int    n_cmp = 0;
  int    n_mis = 0;
  wr_t   wexp;
  done_t dexp;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int rr_winner();
    int w;
    w = -1;
    for (int k = 0; k < N_REQ; k++) begin
      if (w < 0 && bus.req_valid[(exp_ptr + k) % N_REQ]) w = (exp_ptr + k) % N_REQ;
    end
    return w;
  endfunction

  task automatic predict(input int g, input int t0);
    logic [7:0] d[3];
    int         t;
    logic       stop;
    logic       ab;
    logic [1:0] eb;
    wr_t        w;
    done_t      dn;
    d[0] = bus.req_payload_0[g*8 +: 8];
    d[1] = bus.req_payload_1[g*8 +: 8];
    d[2] = {3'b000, bus.req_data_size[g*5 +: 5]};
    t  = t0 + 1;
    ab = 1'b0;
    eb = 2'd0;
    for (int b = 0; b < 3; b++) begin
      stop = ab;
      for (int a = 0; a <= MAX_RETRY; a++) begin
        if (!stop) begin
          w.wsel = 2'(b);
          w.data = d[b];
          w.cyc  = 32'(t);
          write_q.push_back(w);
          t = t + 2;
          if (a >= fails[b]) stop = 1'b1;
          else if (a == MAX_RETRY) begin
            stop = 1'b1;
            ab   = 1'b1;
            eb   = 2'(b);
          end
        end
      end
    end
    dn.id   = ID_W'(g);
    dn.err  = ab;
    dn.beat = eb;
    dn.cyc  = 32'(t);
    done_q.push_back(dn);
  endtask

  // Monitor and requester/slave model.
  initial begin
    last_issue = 1'b0;
    fail_next  = 1'b0;
    pend_g     = -1;
    forever begin
      @(negedge hclk);
      if (hreset) begin
        last_issue = 1'b0;
        pend_g     = -1;
      end else begin
        if (bus.req_ready != '0) begin
          win = rr_winner();
          chk("req_ready", 32'(bus.req_ready), (win < 0) ? 32'd0 : 32'(1 << win));
          if (win >= 0) begin
            predict(win, cyc);
            for (int b = 0; b < 3; b++) att[b] = 0;
            exp_ptr = (win + 1) % N_REQ;
            pend_g  = win;
          end
        end
        if (bus.hsel_x || bus.hwrite || bus.hready) begin
          chk("bus_strobes", 32'({bus.hsel_x, bus.hwrite, bus.hready}), 32'd7);
          chk("write_expected", 32'(write_q.size() > 0), 32'd1);
          if (write_q.size() > 0) begin
            wexp = write_q.pop_front();
            chk("write_select", 32'(bus.write_select), 32'(wexp.wsel));
            chk("hwdata", 32'(bus.hwdata), 32'(wexp.data));
            chk("write_cycle", 32'(cyc), wexp.cyc);
          end
          if (int'(bus.write_select) < 3) begin
            fail_next = (att[bus.write_select] < fails[bus.write_select]);
            att[bus.write_select]++;
          end else fail_next = 1'b0;
          last_issue = 1'b1;
        end else begin
          last_issue = 1'b0;
        end
        if (bus.done_valid) begin
          chk("done_expected", 32'(done_q.size() > 0), 32'd1);
          if (done_q.size() > 0) begin
            dexp = done_q.pop_front();
            chk("done_id", 32'(bus.done_id), 32'(dexp.id));
            chk("done_err", 32'(bus.done_err), 32'(dexp.err));
            chk("done_beat", 32'(bus.done_beat), 32'(dexp.beat));
            chk("done_cycle", 32'(cyc), dexp.cyc);
          end
        end
      end
      @(posedge hclk);
      #1;
      bus.hresp = last_issue ? fail_next : noise;
      if (pend_g >= 0) begin
        bus.req_payload_0[pend_g*8 +: 8] = 8'($urandom);
        bus.req_payload_1[pend_g*8 +: 8] = 8'($urandom);
        bus.req_data_size[pend_g*5 +: 5] = 5'($urandom);
        jobs_left[pend_g]--;
        bus.req_valid[pend_g] = (jobs_left[pend_g] > 0);
        pend_g = -1;
      end
    end
  end

  task automatic give_jobs(input int r, input int n);
    jobs_left[r]     = n;
    bus.req_valid[r] = (n > 0);
  endtask

  task automatic drain(input string tag);
    int k;
    int pending;
    k = 0;
    pending = 1;
    while (pending != 0 && k < 300) begin
      @(negedge hclk);
      k++;
      pending = write_q.size() + done_q.size() + int'(bus.busy);
      for (int i = 0; i < N_REQ; i++) pending += jobs_left[i];
    end
    chk(tag, 32'(pending), 32'd0);
    @(posedge hclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_hsel"}, 32'(bus.hsel_x), 32'd0);
    chk({tag, "_hwrite"}, 32'(bus.hwrite), 32'd0);
    chk({tag, "_hready"}, 32'(bus.hready), 32'd0);
    chk({tag, "_wsel"}, 32'(bus.write_select), 32'd0);
    chk({tag, "_hwdata"}, 32'(bus.hwdata), 32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_done"}, 32'({bus.done_valid, bus.done_id, bus.done_err, bus.done_beat}), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int  k;
    logic hit;
    bus.req_valid     = '0;
    bus.req_payload_0 = '0;
    bus.req_payload_1 = '0;
    bus.req_data_size = '0;
    bus.hresp         = 1'b0;
    noise   = 1'b0;
    exp_ptr = 0;
    for (int b = 0; b < 3; b++) begin
      fails[b] = 0;
      att[b]   = 0;
    end
    for (int i = 0; i < N_REQ; i++) jobs_left[i] = 0;

    hreset = 1'b1;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_all_zero("reset");
    hreset = 1'b0;

    // 1: single error-free job from requester 0
    @(posedge hclk);
    #1;
    bus.req_payload_0[7:0] = 8'hA5;
    bus.req_payload_1[7:0] = 8'h3C;
    bus.req_data_size[4:0] = 5'd17;
    give_jobs(0, 1);
    drain("t1_drain");

    // 2: both requesters valid from a fresh pointer
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    hreset  = 1'b0;
    exp_ptr = 0;
    bus.req_payload_0[15:8] = 8'h5A;
    bus.req_payload_1[15:8] = 8'hC3;
    bus.req_data_size[9:5]  = 5'd31;
    give_jobs(0, 2);
    give_jobs(1, 1);
    drain("t2_drain");

    // 3: one error in the beat-1 check
    fails[1] = 1;
    give_jobs(0, 1);
    drain("t3_drain");
    fails[1] = 0;

    // 4: beat 0 fails on every attempt
    fails[0] = 3;
    give_jobs(0, 1);
    drain("t4_drain");
    fails[0] = 0;

    // 5: reset during the beat-1 issue cycle
    give_jobs(1, 1);
    k   = 0;
    hit = 1'b0;
    while (!hit && k < 50) begin
      @(negedge hclk);
      k++;
      hit = bus.hsel_x && (bus.write_select == 2'd1);
    end
    chk("t5_trigger", 32'(hit), 32'd1);
    hreset        = 1'b1;
    bus.req_valid = '0;
    for (int i = 0; i < N_REQ; i++) jobs_left[i] = 0;
    @(negedge hclk);
    check_all_zero("t5_reset");
    write_q.delete();
    done_q.delete();
    exp_ptr = 0;
    hreset  = 1'b0;
    @(posedge hclk);
    #1;
    give_jobs(0, 1);
    give_jobs(1, 1);
    drain("t5_drain");

    // 6: hresp asserted outside check cycles
    noise = 1'b1;
    give_jobs(0, 1);
    give_jobs(1, 1);
    drain("t6_drain");
    noise = 1'b0;

    repeat (3) @(posedge hclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
